// File: rtl/nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares an external 4-bit ripple-carry slice, one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining NIBBLE_SEQ_ADDER_OVF_EN.
module nibble_seq_adder #(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_ci,
  input  logic [3:0]       slice_s,
  input  logic             slice_co
);

  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [IDXW-1:0]   idx;
  logic              last_nib;

  assign last_nib = (idx == IDXW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Slice pins are decoded from registers only, so they settle well before each edge.
  always_comb begin
    next_state = state;
    slice_a    = 4'h0;
    slice_b    = 4'h0;
    slice_ci   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          next_state = RUN;
        end
      end
      RUN: begin
        slice_a  = a_r[4*idx +: 4];
        slice_b  = b_r[4*idx +: 4];
        slice_ci = carry_r;
        if (last_nib) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // in_ready tracks the upcoming state so it stays low throughout reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      idx       <= '0;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= ci;
            idx     <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_s;
          carry_r         <= slice_co;
          if (last_nib) begin
            co        <= slice_co;
            out_valid <= 1'b1;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
            // The final slice nibble carries the result MSB.
            ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_s[3] != a_r[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Self-checking bench for nibble_seq_adder: directed cases, then randomized traffic against an a+b+ci scoreboard.
// The 4-bit slice is modelled behaviourally here.
module tb_nibble_seq_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
  logic             ovf;
`endif
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_ci;
  logic [3:0]       slice_s;
  logic             slice_co;

  int vectors     = 0;
  int miscompares = 0;

  nibble_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
`ifdef NIBBLE_SEQ_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_ci  (slice_ci),
    .slice_s   (slice_s),
    .slice_co  (slice_co)
  );

  assign {slice_co, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_ci};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operand set, then tracks cycles to out_valid and the slice carry-in per RUN cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic civ,
                               output logic [NIB-1:0] cis, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    ci       = civ;
    tick();
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    ci       = 1'($urandom);
    cis      = '0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      if (lat < NIB) cis[lat] = slice_ci;
      tick();
      lat++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [NIB-1:0] cis;
    int             lat;
    logic [WIDTH:0] expq[$];
    logic [WIDTH:0] model;
    int             accepted;
    int             results;
    int             cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ci        = 1'b0;

    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_outputs", {in_ready, out_valid, co, sum}, 32'd0);
    checkOutput("reset_slice", {slice_a, slice_b, slice_ci}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] basic add 1234+1111");
    applyStimulus(16'h1234, 16'h1111, 1'b0, cis, lat);
    checkOutput("basic_latency", 32'(lat), 32'd4);
    checkOutput("basic_result", {co, sum}, {15'd0, 1'b0, 16'h2345});
    checkOutput("basic_slices_idle_in_done", {slice_a, slice_b, slice_ci}, 32'd0);
    releaseResult();

    $display("[TB] full carry ripple FFFF+0+1");
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, cis, lat);
    checkOutput("ripple_latency", 32'(lat), 32'd4);
    checkOutput("ripple_slice_ci", 32'(cis), 32'hF);
    checkOutput("ripple_result", {co, sum}, {15'd0, 1'b1, 16'h0000});
    releaseResult();

    $display("[TB] DONE stall with in_valid pulses");
    applyStimulus(16'hF00F, 16'h1FF1, 1'b0, cis, lat);
    checkOutput("stall_result", {co, sum}, {15'd0, 1'b1, 16'h1000});
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      a        = 16'h1111;
      b        = 16'h1111;
      tick();
      checkOutput("stall_hold", {in_ready, out_valid, co, sum}, {13'd0, 1'b0, 1'b1, 1'b1, 16'h1000});
    end
    in_valid = 1'b0;
    releaseResult();
    applyStimulus(16'h0005, 16'h0003, 1'b0, cis, lat);
    checkOutput("after_stall_result", {co, sum}, {15'd0, 1'b0, 16'h0008});
    releaseResult();

    $display("[TB] async reset during RUN");
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1111;
    ci       = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("mid_run_slice_a", 32'(slice_a), 32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {in_ready, out_valid, co, sum}, 32'd0);
    checkOutput("async_reset_slice", {slice_a, slice_b, slice_ci}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("reset_recover_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_recover_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, cis, lat);
    checkOutput("reset_recover_result", {co, sum}, {15'd0, 1'b0, 16'h0002});
    releaseResult();

`ifdef NIBBLE_SEQ_ADDER_OVF_EN
    $display("[TB] signed overflow");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, cis, lat);
    checkOutput("ovf_pos_result", {ovf, co, sum}, {14'd0, 1'b1, 1'b0, 16'h8000});
    releaseResult();
    checkOutput("ovf_cleared", 32'(ovf), 32'd0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, cis, lat);
    checkOutput("ovf_neg_result", {ovf, co, sum}, {14'd0, 1'b1, 1'b1, 16'h0000});
    releaseResult();
    applyStimulus(16'h1000, 16'h2000, 1'b0, cis, lat);
    checkOutput("ovf_none_result", {ovf, co, sum}, {14'd0, 1'b0, 1'b0, 16'h3000});
    releaseResult();
`endif

    $display("[TB] random traffic");
    accepted = 0;
    results  = 0;
    cyc      = 0;
    while (results < 1000 && cyc < 60000) begin
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      a         = WIDTH'($urandom);
      b         = WIDTH'($urandom);
      ci        = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        model = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        expq.push_back(model);
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("rnd_spurious_result", 32'(out_valid), 32'd0);
        end else begin
          model = expq.pop_front();
          checkOutput("rnd_result", 32'({co, sum}), 32'(model));
        end
        results++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("rnd_result_count", 32'(results), 32'd1000);
    checkOutput("rnd_queue_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_seq_adder.md
Name: nibble_seq_adder

Overview:
- Multi-cycle wide adder controller. Accepts WIDTH-bit operands over a valid/ready handshake.
- Feeds them one nibble per cycle, LSB first, into an external 4-bit ripple-carry slice (rca4). Collects the slice sum and carry each cycle.
- Presents the full WIDTH-bit result and carry-out on a valid/ready output handshake.
- Sits directly upstream and downstream of the 4-bit slice: drives its a/b/ci pins and consumes its s/co pins.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of slice passes. Derived; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- co  out  1  registered carry-out
- slice_a  out  4  to rca4 a
- slice_b  out  4  to rca4 b
- slice_ci  out  1  to rca4 ci
- slice_s  in  4  from rca4 s (combinational)
- slice_co  in  1  from rca4 co (combinational)

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0 while rst_n low; out_valid=0, sum=0, co=0, slice_a=0, slice_b=0, slice_ci=0. Internal operand regs, carry reg and nibble index cleared. Reset mid-RUN or mid-DONE aborts the operation; the result is lost.
- States: IDLE, RUN, DONE. Next-state logic is Moore; all outputs except slice_* are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a, b into a_r, b_r; carry_r<=ci; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - slice_a=a_r[4*idx+:4], slice_b=b_r[4*idx+:4], slice_ci=carry_r. Combinational from registers, so glitch-free at the edge.
  - Each edge: sum[4*idx+:4]<=slice_s; carry_r<=slice_co; idx<=idx+1.
  - When idx==NIB-1, the same edge also sets co<=slice_co and out_valid<=1, and goes to DONE.
- DONE:
  - out_valid=1; sum and co are held stable; in_ready=0; slice_* driven to 0.
  - On out_valid&&out_ready at an edge: out_valid<=0; go to IDLE.
  - No back-to-back accept in the same cycle.
- Slice outputs are 0 in IDLE and DONE.
- Latency: accept edge E0, then out_valid is high after edge E0+NIB (4 cycles for WIDTH=16).
- Throughput: one result per NIB+2 cycles at best.
- sum bits of nibbles not yet written hold their previous value during RUN. The consumer reads sum only when out_valid=1.
- Arithmetic: {co,sum} = a + b + ci, modulo 2^(WIDTH+1). The sum is exact; no saturation.
- in_valid while not ready is ignored. Operands are sampled only at the accept edge; later changes to a/b have no effect.
- out_ready while out_valid=0 is ignored.
- idx width: clog2(NIB), minimum 1 bit. It wraps only via reset or re-accept, never past NIB-1.

Optional Feature:
- Macro NIBBLE_SEQ_ADDER_OVF_EN.
- Defined: adds output port ovf (out, 1). ovf is the signed two's-complement overflow, (a_r[WIDTH-1]==b_r[WIDTH-1]) && (sum[WIDTH-1]!=a_r[WIDTH-1]).
  - Registered at the final RUN edge together with co.
  - Reset 0; held through DONE; cleared on the output handshake.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset then a=16'h1234, b=16'h1111, ci=0 → out_valid rises exactly 4 cycles after accept; sum=16'h2345, co=0.
- a=16'hFFFF, b=16'h0000, ci=1 → carry ripples through all slices; sum=16'h0000, co=1. slice_ci observed as 1,1,1,1 across the RUN cycles.
- Hold out_ready=0 for 5 cycles in DONE, with in_valid pulsed meanwhile → sum/co stable, in_ready=0, new operands ignored. Release out_ready → IDLE next cycle, then the next operand is accepted.
- Assert rst_n=0 on the 2nd RUN cycle → all outputs 0 immediately (async). After release: IDLE, in_ready=1, and a fresh add of 16'h0001+16'h0001 gives 16'h0002.
- With NIBBLE_SEQ_ADDER_OVF_EN: a=16'h7FFF, b=16'h0001, ci=0 → sum=16'h8000, co=0, ovf=1. Then a=16'h8000, b=16'h8000 → sum=16'h0000, co=1, ovf=1.
- Random 1000 transactions with random in_valid/out_ready stalls → {co,sum} matches the a+b+ci scoreboard; no lost or duplicated results.
